// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light lamp monitor: phase encodings,
// lamp patterns {R1,Y1,G1,R2,Y2,G2}, decode table and sequencing rules.
package traffic_pkg;

    localparam logic [2:0] PH_NIGHT   = 3'd0;
    localparam logic [2:0] PH_G1      = 3'd1;
    localparam logic [2:0] PH_G1TO2   = 3'd2;
    localparam logic [2:0] PH_G2      = 3'd3;
    localparam logic [2:0] PH_G2TO1   = 3'd4;
    localparam logic [2:0] PH_INVALID = 3'd7;

    localparam logic [5:0] PAT_NIGHT  = 6'b010010;
    localparam logic [5:0] PAT_G1     = 6'b001100;
    localparam logic [5:0] PAT_G1TO2  = 6'b010100;
    localparam logic [5:0] PAT_G2     = 6'b100001;
    localparam logic [5:0] PAT_G2TO1  = 6'b100010;

    typedef enum logic {
        MON_WAIT,
        MON_TRACK
    } mon_state_t;

    // Map an accepted lamp pattern back to the controller phase.
    function automatic logic [2:0] decode_pattern(input logic [5:0] pat);
        logic [2:0] ph;
        case (pat)
            PAT_NIGHT: ph = PH_NIGHT;
            PAT_G1:    ph = PH_G1;
            PAT_G1TO2: ph = PH_G1TO2;
            PAT_G2:    ph = PH_G2;
            PAT_G2TO1: ph = PH_G2TO1;
            default:   ph = PH_INVALID;
        endcase
        return ph;
    endfunction

    // Night is always reachable, and anything may follow an invalid pattern.
    function automatic logic legal_next(input logic [2:0] from_ph, input logic [2:0] to_ph);
        logic ok;
        if (to_ph == PH_NIGHT || from_ph == PH_INVALID) begin
            ok = 1'b1;
        end else begin
            case (from_ph)
                PH_NIGHT: ok = (to_ph == PH_G1);
                PH_G1:    ok = (to_ph == PH_G1TO2);
                PH_G1TO2: ok = (to_ph == PH_G2);
                PH_G2:    ok = (to_ph == PH_G2TO1);
                PH_G2TO1: ok = (to_ph == PH_G1);
                default:  ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // A green on one side together with green or yellow on the other.
    function automatic logic lamp_conflict(input logic [5:0] pat);
        return (pat[3] & (pat[0] | pat[1])) | (pat[0] & (pat[3] | pat[4]));
    endfunction

endpackage

// File: rtl/traffic_light_monitor_lamp_filter.sv
// lamp_filter: 2-flop synchroniser for the six lamp lines followed by a
// stability counter. accept pulses for one cycle on the STABLE_CYCLES-th
// consecutive identical sample; pattern carries the sample being accepted.
module lamp_filter #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] lamps_in,
    output logic [5:0] pattern,
    output logic       accept
);

    localparam int CW = $clog2(STABLE_CYCLES + 1) + 1;
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    logic [5:0]    sync1, sync2, cand;
    logic [1:0]    fill;
    logic [CW-1:0] run_cnt, run_next;
    logic          same;

    // Synchroniser; fill marks when sync2 holds real lamp data rather than reset zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            fill  <= '0;
        end else begin
            sync1 <= lamps_in;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
        end
    end

    // Length of the current run of identical samples, saturating at STABLE_CYCLES.
    always_comb begin
        same = (sync2 == cand) && (run_cnt != '0);
        if (!same)
            run_next = CW'(1);
        else if (run_cnt == STABLE_MAX)
            run_next = STABLE_MAX;
        else
            run_next = run_cnt + 1'b1;
    end

    // Fires once per run, the cycle the run reaches the required length.
    assign accept  = fill[1] && (run_next == STABLE_MAX) && !(same && run_cnt == STABLE_MAX);
    assign pattern = sync2;

    // Track the candidate pattern and its run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand    <= '0;
            run_cnt <= '0;
        end else if (fill[1]) begin
            cand    <= sync2;
            run_cnt <= run_next;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: watches the six lamp lines of a two-direction
// traffic light, decodes the phase, flags illegal sequencing, conflicts and
// invalid patterns, and measures each phase's length in whole seconds.
// Optional: define TRAFFIC_MON_DUR_CHECK_EN to compare measured green/yellow
// durations against exp_rg_cnt/exp_y_cnt (err_dur); otherwise err_dur is 0.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int CNT_WIDTH     = 11,
    parameter int TICK_DIV      = 12_000_000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 R1,
    input  logic                 Y1,
    input  logic                 G1,
    input  logic                 R2,
    input  logic                 Y2,
    input  logic                 G2,
    input  logic                 clr_err,
    input  logic [CNT_WIDTH-1:0] exp_rg_cnt,
    input  logic [CNT_WIDTH-1:0] exp_y_cnt,
    output logic [2:0]           phase,
    output logic                 phase_valid,
    output logic [CNT_WIDTH-1:0] last_dur,
    output logic                 dur_valid,
    output logic                 err_seq,
    output logic                 err_conflict,
    output logic                 err_invalid,
    output logic                 err_dur
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

    mon_state_t           state;
    logic [5:0]           flt_pat;
    logic                 flt_acc;
    logic [2:0]           acc_phase;
    logic [DIV_W-1:0]     div_cnt;
    logic [CNT_WIDTH-1:0] sec_cnt, sec_inc, meas;
    logic                 tick, dur_bad;

    lamp_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .clk      (clk),
        .rst      (rst),
        .lamps_in ({R1, Y1, G1, R2, Y2, G2}),
        .pattern  (flt_pat),
        .accept   (flt_acc)
    );

    assign acc_phase = decode_pattern(flt_pat);
    assign tick      = (div_cnt == DIV_LAST);
    assign sec_inc   = (sec_cnt == CNT_MAX) ? sec_cnt : sec_cnt + 1'b1;
    // Include a tick landing on the transition edge itself.
    assign meas      = tick ? sec_inc : sec_cnt;

`ifdef TRAFFIC_MON_DUR_CHECK_EN
    localparam logic signed [CNT_WIDTH:0] DIFF_ONE = (CNT_WIDTH+1)'(1);
    logic [CNT_WIDTH-1:0]        exp_sel;
    logic                        chk_en;
    logic signed [CNT_WIDTH:0]   dur_diff;

    // Expected duration is chosen by the phase being left; night/invalid are unchecked.
    always_comb begin
        exp_sel = exp_rg_cnt;
        chk_en  = 1'b0;
        case (phase)
            PH_G1, PH_G2: begin
                exp_sel = exp_rg_cnt;
                chk_en  = 1'b1;
            end
            PH_G1TO2, PH_G2TO1: begin
                exp_sel = exp_y_cnt;
                chk_en  = 1'b1;
            end
            default: ;
        endcase
        dur_diff = $signed({1'b0, meas}) - $signed({1'b0, exp_sel});
        dur_bad  = chk_en && ((dur_diff > DIFF_ONE) || (dur_diff < -DIFF_ONE));
    end
`else
    logic unused_exp;
    assign unused_exp = ^{exp_rg_cnt, exp_y_cnt};
    assign dur_bad    = 1'b0;
    assign err_dur    = 1'b0;
`endif

    // Monitor FSM, duration counters and sticky error flags; set wins over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= MON_WAIT;
            phase        <= PH_INVALID;
            phase_valid  <= 1'b0;
            last_dur     <= '0;
            dur_valid    <= 1'b0;
            err_seq      <= 1'b0;
            err_conflict <= 1'b0;
            err_invalid  <= 1'b0;
`ifdef TRAFFIC_MON_DUR_CHECK_EN
            err_dur      <= 1'b0;
`endif
            div_cnt      <= '0;
            sec_cnt      <= '0;
        end else begin
            dur_valid <= 1'b0;
            if (clr_err) begin
                err_seq      <= 1'b0;
                err_conflict <= 1'b0;
                err_invalid  <= 1'b0;
`ifdef TRAFFIC_MON_DUR_CHECK_EN
                err_dur      <= 1'b0;
`endif
            end
            if (tick) begin
                div_cnt <= '0;
                sec_cnt <= sec_inc;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (flt_acc) begin
                if (lamp_conflict(flt_pat))
                    err_conflict <= 1'b1;
                case (state)
                    MON_WAIT: begin
                        state       <= MON_TRACK;
                        phase       <= acc_phase;
                        phase_valid <= 1'b1;
                        div_cnt     <= '0;
                        sec_cnt     <= '0;
                    end
                    MON_TRACK: begin
                        if (acc_phase != phase) begin
                            if (!legal_next(phase, acc_phase))
                                err_seq <= 1'b1;
                            if (phase != PH_INVALID && acc_phase == PH_INVALID)
                                err_invalid <= 1'b1;
`ifdef TRAFFIC_MON_DUR_CHECK_EN
                            if (dur_bad)
                                err_dur <= 1'b1;
`endif
                            last_dur  <= meas;
                            dur_valid <= 1'b1;
                            phase     <= acc_phase;
                            div_cnt   <= '0;
                            sec_cnt   <= '0;
                        end
                    end
                    default: state <= MON_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed and random lamp segments; a
// segment-level model predicts every phase transition (queued, checked when
// dur_valid pulses) and the phase/error state at the end of each segment.
module tb_traffic_light_monitor;

    localparam int CW = 11;
    localparam int TD = 10;
    localparam int SC = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    lamps = 6'b010010;
    logic          clr_err = 1'b0;
    logic [CW-1:0] exp_rg_cnt = 11'd8;
    logic [CW-1:0] exp_y_cnt = 11'd6;
    logic [2:0]    phase;
    logic          phase_valid, dur_valid;
    logic [CW-1:0] last_dur;
    logic          err_seq, err_conflict, err_invalid, err_dur;

    traffic_light_monitor #(.CNT_WIDTH(CW), .TICK_DIV(TD), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst),
        .R1(lamps[5]), .Y1(lamps[4]), .G1(lamps[3]),
        .R2(lamps[2]), .Y2(lamps[1]), .G2(lamps[0]),
        .clr_err(clr_err), .exp_rg_cnt(exp_rg_cnt), .exp_y_cnt(exp_y_cnt),
        .phase(phase), .phase_valid(phase_valid), .last_dur(last_dur), .dur_valid(dur_valid),
        .err_seq(err_seq), .err_conflict(err_conflict), .err_invalid(err_invalid), .err_dur(err_dur)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ph;
        int         dur;
        logic [3:0] errs;
    } ev_t;

    ev_t evq[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model state
    bit  m_wait = 1'b1;
    int  m_phase = 7;
    int  m_cyc = 0;
    bit  m_seq, m_conf, m_inv, m_dur;
    logic [5:0] tbl[5] = '{6'b010010, 6'b001100, 6'b010100, 6'b100001, 6'b100010};

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_phase(input logic [5:0] p);
        for (int i = 0; i < 5; i++)
            if (p == tbl[i]) return i;
        return 7;
    endfunction

    function automatic bit ref_legal(input int a, input int b);
        if (b == 0 || a == 7) return 1'b1;
        if (a == 4) return b == 1;
        return b == a + 1;
    endfunction

    function automatic logic [3:0] m_errs();
        return {m_seq, m_conf, m_inv, m_dur};
    endfunction

    // Scoreboard side: every dur_valid must match the oldest predicted transition.
    always @(negedge clk) begin
        ev_t e;
        if (!rst && dur_valid) begin
            if (evq.size() == 0) begin
                check("unexpected_dur_valid", int'(dur_valid), 0);
            end else begin
                e = evq.pop_front();
                check("ev_phase", int'(phase), e.ph);
                check("ev_last_dur", int'(last_dur), e.dur);
                check("ev_errs", int'({err_seq, err_conflict, err_invalid, err_dur}), int'(e.errs));
            end
        end
    end

    task automatic check_state(input string tag);
        check({tag, "_phase"}, int'(phase), m_phase);
        check({tag, "_phase_valid"}, int'(phase_valid), 1);
        check({tag, "_errs"}, int'({err_seq, err_conflict, err_invalid, err_dur}), int'(m_errs()));
    endtask

    // Assert reset for one cycle with lamps showing pat; outputs must clear at once.
    task automatic do_reset(input logic [5:0] pat);
        check("evq_empty_before_reset", evq.size(), 0);
        evq.delete();
        @(negedge clk);
        rst = 1'b1;
        lamps = pat;
        #1;
        check("rst_phase", int'(phase), 7);
        check("rst_phase_valid", int'(phase_valid), 0);
        check("rst_last_dur", int'(last_dur), 0);
        check("rst_dur_valid", int'(dur_valid), 0);
        check("rst_errs", int'({err_seq, err_conflict, err_invalid, err_dur}), 0);
        @(negedge clk);
        rst = 1'b0;
        m_wait = 1'b1; m_phase = 7; m_cyc = 0;
        m_seq = 0; m_conf = 0; m_inv = 0; m_dur = 0;
    endtask

    // One lamp segment: pat for hold cycles, optionally a short glitch then pat again for h2.
    task automatic seg(input logic [5:0] pat, input int hold,
                       input int g_len = 0, input logic [5:0] g_pat = 6'b0, input int h2 = 0);
        int dec, dur, d;
        dec = ref_phase(pat);
        if ((pat[3] && (pat[0] || pat[1])) || (pat[0] && (pat[3] || pat[4]))) m_conf = 1'b1;
        if (m_wait) begin
            m_wait = 1'b0; m_phase = dec; m_cyc = 0;
        end else if (dec != m_phase) begin
            if (!ref_legal(m_phase, dec)) m_seq = 1'b1;
            if (m_phase != 7 && dec == 7) m_inv = 1'b1;
            dur = m_cyc / TD;
            if (dur > SAT) dur = SAT;
`ifdef TRAFFIC_MON_DUR_CHECK_EN
            if (m_phase == 1 || m_phase == 3) d = dur - int'(exp_rg_cnt);
            else if (m_phase == 2 || m_phase == 4) d = dur - int'(exp_y_cnt);
            else d = 0;
            if (d > 1 || d < -1) m_dur = 1'b1;
`else
            d = 0;
`endif
            evq.push_back('{dec, dur, m_errs()});
            m_phase = dec;
            m_cyc = 0;
        end
        lamps = pat;
        repeat (hold) @(negedge clk);
        if (g_len > 0) begin
            lamps = g_pat;
            repeat (g_len) @(negedge clk);
            lamps = pat;
            repeat (h2) @(negedge clk);
        end
        m_cyc += hold + g_len + h2;
        check_state("seg");
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_seq = 0; m_conf = 0; m_inv = 0; m_dur = 0;
        m_cyc += 1;
        check("clr_errs", int'({err_seq, err_conflict, err_invalid, err_dur}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] prev, p, g;
        int r;
        do_reset(tbl[0]);
        // Normal cycle with the 80/60 holds
        seg(tbl[0], 20);
        seg(tbl[1], 80);
        seg(tbl[2], 60);
        seg(tbl[3], 30);
        seg(tbl[4], 20);
        // Short conflicting glitch inside group1
        seg(tbl[1], 10, 3, 6'b001001, 20);
        // Illegal skip group1 -> group2, then clear
        seg(tbl[3], 20);
        pulse_clr();
        // Conflicting invalid pattern, clear, then night
        seg(6'b001001, 20);
        pulse_clr();
        seg(tbl[0], 20);
        // Duration check cases: 100 and 90 cycles of green
        seg(tbl[1], 100);
        seg(tbl[2], 20);
        pulse_clr();
        seg(tbl[3], 90);
        pulse_clr();
        seg(tbl[4], 20);
        // Seconds counter saturation
        seg(tbl[1], 20_600);
        seg(tbl[0], 15);
        // Reset in the middle of group2
        seg(tbl[1], 20);
        seg(tbl[2], 20);
        seg(tbl[3], 15);
        do_reset(tbl[3]);
        seg(tbl[3], 20);
        seg(tbl[4], 20);
        // Random segments
        prev = tbl[4];
        for (int n = 0; n < 80; n++) begin
            do begin
                r = $urandom_range(0, 7);
                if (r < 5) p = tbl[r];
                else p = 6'($urandom_range(0, 63));
            end while (p == prev);
            if ($urandom_range(0, 9) < 3) begin
                do g = 6'($urandom_range(0, 63)); while (g == p);
                seg(p, $urandom_range(6, 15), $urandom_range(1, SC - 1), g, $urandom_range(6, 15));
            end else if ($urandom_range(0, 9) < 2) begin
                seg(p, $urandom_range(60, 150));
            end else begin
                seg(p, $urandom_range(6, 40));
            end
            if ($urandom_range(0, 9) < 2) pulse_clr();
            prev = p;
        end
        repeat (10) @(negedge clk);
        check("leftover_events", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
